erasable_access_arbiter: RTL and testbench

ERASABLE_ACCESS_ARBITER -- requirements
Module: erasable_access_arbiter

---
 rtl/erasable_access_arbiter.sv | 154 +++++++++++++++
 tb/tb_erasable_access_arbiter.sv | 471 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/erasable_access_arbiter.sv
// Two-requester (core / monitor) arbiter for an asynchronous erasable memory.
// Sequences SETUP / ACCESS / HOLD strobes with a starvation guard for the monitor.
module erasable_access_arbiter #(
    parameter int unsigned ACCESS_CYCLES = 2,
    parameter int unsigned STARVE_LIMIT  = 4,
    localparam int unsigned AW = 11,
    localparam int unsigned DW = 16
) (
    input  logic          SIM_CLK,
    input  logic          SIM_RST,
    input  logic          CORE_REQ,
    input  logic          CORE_WE,
    input  logic [AW-1:0] CORE_ADDR,
    input  logic [DW-1:0] CORE_WDATA,
    output logic          CORE_ACK,
    input  logic          MON_REQ,
    input  logic          MON_WE,
    input  logic [AW-1:0] MON_ADDR,
    input  logic [DW-1:0] MON_WDATA,
    output logic          MON_ACK,
    output logic [DW-1:0] RDATA,
    output logic          BUSY,
    output logic [AW-1:0] MEM_ADDR,
    output logic          MEM_CE_n,
    output logic          MEM_OE_n,
    output logic          MEM_WE_n,
    output logic [DW-1:0] MEM_DOUT,
    output logic          MEM_DOE,
    input  logic [DW-1:0] MEM_DIN
);

    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] ACC_LOAD   = CW'(ACCESS_CYCLES);
    localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] starve_q, starve_d;
    logic          we_q, we_d;
    logic          own_mon_q, own_mon_d;
    logic [AW-1:0] addr_d;
    logic [DW-1:0] wdata_d;
    logic          grant_mon;
    logic          rdata_capture;
    logic          ce_n_d, oe_n_d, we_n_d, doe_d, core_ack_d, mon_ack_d, busy_d;

    // State register
    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, arbitration and next-cycle output values
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        starve_d      = starve_q;
        we_d          = we_q;
        own_mon_d     = own_mon_q;
        addr_d        = MEM_ADDR;
        wdata_d       = MEM_DOUT;
        grant_mon     = MON_REQ && (!CORE_REQ || (STARVE_LIMIT != 0 && starve_q == STARVE_MAX));
        rdata_capture = 1'b0;

        case (state_q)
            IDLE: begin
                if (!MON_REQ) begin
                    starve_d = '0;
                end
                if (CORE_REQ || MON_REQ) begin
                    state_d   = SETUP;
                    own_mon_d = grant_mon;
                    we_d      = grant_mon ? MON_WE    : CORE_WE;
                    addr_d    = grant_mon ? MON_ADDR  : CORE_ADDR;
                    wdata_d   = grant_mon ? MON_WDATA : CORE_WDATA;
                    if (grant_mon) begin
                        starve_d = '0;
                    end else if (MON_REQ && starve_q < STARVE_MAX) begin
                        starve_d = starve_q + CW'(1);
                    end
                end
            end
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = ACC_LOAD;
            end
            ACCESS: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q <= CW'(1)) begin
                    state_d       = HOLD;
                    rdata_capture = !we_q;
                end
            end
            HOLD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Strobes are registered, so they are derived from the state being entered
        ce_n_d     = (state_d == IDLE);
        oe_n_d     = !(state_d == ACCESS && !we_d);
        we_n_d     = !(state_d == ACCESS && we_d);
        doe_d      = (state_d != IDLE) && we_d;
        core_ack_d = (state_d == HOLD) && !own_mon_d;
        mon_ack_d  = (state_d == HOLD) && own_mon_d;
        busy_d     = (state_d != IDLE);
    end

    // Datapath, counters and registered outputs
    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            cnt_q     <= '0;
            starve_q  <= '0;
            we_q      <= 1'b0;
            own_mon_q <= 1'b0;
            MEM_ADDR  <= '0;
            MEM_DOUT  <= '0;
            RDATA     <= '0;
            MEM_CE_n  <= 1'b1;
            MEM_OE_n  <= 1'b1;
            MEM_WE_n  <= 1'b1;
            MEM_DOE   <= 1'b0;
            CORE_ACK  <= 1'b0;
            MON_ACK   <= 1'b0;
            BUSY      <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            starve_q  <= starve_d;
            we_q      <= we_d;
            own_mon_q <= own_mon_d;
            MEM_ADDR  <= addr_d;
            MEM_DOUT  <= wdata_d;
            MEM_CE_n  <= ce_n_d;
            MEM_OE_n  <= oe_n_d;
            MEM_WE_n  <= we_n_d;
            MEM_DOE   <= doe_d;
            CORE_ACK  <= core_ack_d;
            MON_ACK   <= mon_ack_d;
            BUSY      <= busy_d;
            if (rdata_capture) begin
                RDATA <= MEM_DIN;
            end
        end
    end

endmodule

// File: tb/tb_erasable_access_arbiter.sv
// Self-checking bench for erasable_access_arbiter: directed scenarios plus
// randomized traffic compared against a transaction-offset reference model.
module tb_erasable_access_arbiter;

    localparam int AC = 2;
    localparam int SL = 4;

    logic        SIM_CLK = 1'b0;
    logic        SIM_RST;
    logic        CORE_REQ, CORE_WE, MON_REQ, MON_WE;
    logic [10:0] CORE_ADDR, MON_ADDR;
    logic [15:0] CORE_WDATA, MON_WDATA;
    logic        CORE_ACK, MON_ACK, BUSY;
    logic [15:0] RDATA, MEM_DOUT, MEM_DIN;
    logic [10:0] MEM_ADDR;
    logic        MEM_CE_n, MEM_OE_n, MEM_WE_n, MEM_DOE;

    logic        n_core_ack, n_mon_ack, n_busy, n_ce_n, n_oe_n, n_we_n, n_doe;
    logic [15:0] n_rdata, n_dout;
    logic [10:0] n_mem_addr;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] mem_dev [2048];
    logic [15:0] mem_ref [2048];

    always #5 SIM_CLK = ~SIM_CLK;

    erasable_access_arbiter #(.ACCESS_CYCLES(AC), .STARVE_LIMIT(SL)) dut (
        .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST),
        .CORE_REQ(CORE_REQ), .CORE_WE(CORE_WE), .CORE_ADDR(CORE_ADDR),
        .CORE_WDATA(CORE_WDATA), .CORE_ACK(CORE_ACK),
        .MON_REQ(MON_REQ), .MON_WE(MON_WE), .MON_ADDR(MON_ADDR),
        .MON_WDATA(MON_WDATA), .MON_ACK(MON_ACK),
        .RDATA(RDATA), .BUSY(BUSY), .MEM_ADDR(MEM_ADDR),
        .MEM_CE_n(MEM_CE_n), .MEM_OE_n(MEM_OE_n), .MEM_WE_n(MEM_WE_n),
        .MEM_DOUT(MEM_DOUT), .MEM_DOE(MEM_DOE), .MEM_DIN(MEM_DIN)
    );

    // Second instance with pure core priority
    erasable_access_arbiter #(.ACCESS_CYCLES(AC), .STARVE_LIMIT(0)) dut_nostarve (
        .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST),
        .CORE_REQ(CORE_REQ), .CORE_WE(CORE_WE), .CORE_ADDR(CORE_ADDR),
        .CORE_WDATA(CORE_WDATA), .CORE_ACK(n_core_ack),
        .MON_REQ(MON_REQ), .MON_WE(MON_WE), .MON_ADDR(MON_ADDR),
        .MON_WDATA(MON_WDATA), .MON_ACK(n_mon_ack),
        .RDATA(n_rdata), .BUSY(n_busy), .MEM_ADDR(n_mem_addr),
        .MEM_CE_n(n_ce_n), .MEM_OE_n(n_oe_n), .MEM_WE_n(n_we_n),
        .MEM_DOUT(n_dout), .MEM_DOE(n_doe), .MEM_DIN(16'h0000)
    );

    // Memory device: drives junk when output is not enabled
    assign MEM_DIN = MEM_OE_n ? 16'hDEAD : mem_dev[MEM_ADDR];

    always @(posedge SIM_CLK) begin
        if (!MEM_CE_n && !MEM_WE_n && MEM_DOE) mem_dev[MEM_ADDR] = MEM_DOUT;
    end

    // Reference model: one transaction at a time, phase = edges since grant
    int          cyc = 0;
    int          m_g = 0;
    int          m_starve = 0;
    bit          m_active = 1'b0;
    bit          m_mon, m_we;
    logic [10:0] m_addr;
    logic [15:0] m_wdata;
    logic [15:0] exp_rdata = '0, exp_dout = '0;
    logic [10:0] exp_addr = '0;
    logic        exp_ce_n = 1'b1, exp_oe_n = 1'b1, exp_we_n = 1'b1, exp_doe = 1'b0;
    logic        exp_cack = 1'b0, exp_mack = 1'b0, exp_busy = 1'b0;

    always @(posedge SIM_CLK) begin
        int d;
        bit mon_wins;
        bit acc, hold;
        cyc++;
        if (SIM_RST) begin
            m_active  = 1'b0;
            m_starve  = 0;
            exp_rdata = '0;
            exp_addr  = '0;
            exp_dout  = '0;
        end else if (!m_active) begin
            if (!MON_REQ) m_starve = 0;
            if (CORE_REQ || MON_REQ) begin
                mon_wins = MON_REQ && (!CORE_REQ || (SL != 0 && m_starve == SL));
                if (mon_wins) m_starve = 0;
                else if (MON_REQ && m_starve < SL) m_starve++;
                m_mon    = mon_wins;
                m_we     = mon_wins ? MON_WE : CORE_WE;
                m_addr   = mon_wins ? MON_ADDR : CORE_ADDR;
                m_wdata  = mon_wins ? MON_WDATA : CORE_WDATA;
                m_active = 1'b1;
                m_g      = cyc;
                exp_addr = m_addr;
                exp_dout = m_wdata;
            end
        end else begin
            d = cyc - m_g;
            if (d == AC + 1) begin
                if (m_we) mem_ref[m_addr] = m_wdata;
                else exp_rdata = mem_ref[m_addr];
            end
            if (d == AC + 2) m_active = 1'b0;
        end
        d    = cyc - m_g;
        acc  = m_active && d >= 1 && d <= AC;
        hold = m_active && d == AC + 1;
        exp_ce_n = !m_active;
        exp_oe_n = !(acc && !m_we);
        exp_we_n = !(acc && m_we);
        exp_doe  = m_active && m_we;
        exp_cack = hold && !m_mon;
        exp_mack = hold && m_mon;
        exp_busy = m_active;
    end

    task automatic tick();
        @(posedge SIM_CLK);
        #1;
    endtask

    task automatic idle(input int n);
        CORE_REQ = 1'b0;
        MON_REQ  = 1'b0;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        SIM_RST = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({MEM_CE_n, MEM_OE_n, MEM_WE_n, MEM_DOE} !== 4'b1110) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b expected 1110", {MEM_CE_n, MEM_OE_n, MEM_WE_n, MEM_DOE});
        end
        n_checks++;
        if ({CORE_ACK, MON_ACK, BUSY} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ack_busy: got %b expected 000", {CORE_ACK, MON_ACK, BUSY});
        end
        n_checks++;
        if ({RDATA, MEM_ADDR, MEM_DOUT} !== 43'h0) begin
            n_fail++;
            $display("FAIL reset_data: got rdata %0h addr %0h dout %0h expected 0 0 0", RDATA, MEM_ADDR, MEM_DOUT);
        end
        SIM_RST = 1'b0;
        tick();
    endtask

    task automatic test_core_read();
        int ce_low = 0, oe_low = 0, ack_at = -1;
        mem_dev[11'h1A5] = 16'h8123;
        mem_ref[11'h1A5] = 16'h8123;
        CORE_WE   = 1'b0;
        CORE_ADDR = 11'h1A5;
        CORE_REQ  = 1'b1;
        // k = 0 is the grant edge; ACK occupies the cycle ending at grant + AC + 2
        for (int k = 0; k < AC + 6; k++) begin
            tick();
            if (!MEM_CE_n) ce_low++;
            if (!MEM_OE_n) oe_low++;
            if (CORE_ACK) begin
                if (ack_at < 0) ack_at = k;
                CORE_REQ = 1'b0;
            end
        end
        n_checks++;
        if (ce_low != AC + 2) begin
            n_fail++;
            $display("FAIL read_ce_cycles: got %0d expected %0d", ce_low, AC + 2);
        end
        n_checks++;
        if (oe_low != AC) begin
            n_fail++;
            $display("FAIL read_oe_cycles: got %0d expected %0d", oe_low, AC);
        end
        n_checks++;
        if (ack_at != AC + 1) begin
            n_fail++;
            $display("FAIL read_ack_latency: got %0d expected %0d", ack_at, AC + 1);
        end
        n_checks++;
        if (RDATA !== 16'h8123) begin
            n_fail++;
            $display("FAIL read_rdata: got %0h expected 8123", RDATA);
        end
    endtask

    task automatic test_mon_write();
        logic [15:0] rdata_before = RDATA;
        int doe_hi = 0, we_low = 0, acks = 0, bad_bus = 0, core_acks = 0;
        MON_WE    = 1'b1;
        MON_ADDR  = 11'h7FF;
        MON_WDATA = 16'h5555;
        MON_REQ   = 1'b1;
        for (int k = 0; k < AC + 6; k++) begin
            tick();
            if (MEM_DOE) doe_hi++;
            if (!MEM_WE_n) begin
                we_low++;
                if (MEM_DOUT !== 16'h5555 || MEM_ADDR !== 11'h7FF || MEM_CE_n || !MEM_OE_n) bad_bus++;
            end
            if (CORE_ACK) core_acks++;
            if (MON_ACK) begin
                acks++;
                MON_REQ = 1'b0;
            end
        end
        n_checks++;
        if (doe_hi != AC + 2) begin
            n_fail++;
            $display("FAIL write_doe_cycles: got %0d expected %0d", doe_hi, AC + 2);
        end
        n_checks++;
        if (we_low != AC) begin
            n_fail++;
            $display("FAIL write_we_cycles: got %0d expected %0d", we_low, AC);
        end
        n_checks++;
        if (acks != 1 || core_acks != 0) begin
            n_fail++;
            $display("FAIL write_acks: got mon %0d core %0d expected 1 0", acks, core_acks);
        end
        n_checks++;
        if (bad_bus != 0) begin
            n_fail++;
            $display("FAIL write_bus: got %0d bad cycles expected 0", bad_bus);
        end
        n_checks++;
        if (RDATA !== rdata_before) begin
            n_fail++;
            $display("FAIL write_rdata_kept: got %0h expected %0h", RDATA, rdata_before);
        end
        n_checks++;
        if (mem_dev[11'h7FF] !== 16'h5555) begin
            n_fail++;
            $display("FAIL write_memory: got %0h expected 5555", mem_dev[11'h7FF]);
        end
    endtask

    task automatic test_starvation();
        logic [9:0] got = '0, want = '0;
        int n = 0, last = -1, bad_gap = 0, overlap = 0;
        for (int i = 0; i < 10; i++) want[i] = (SL != 0) && ((i % (SL + 1)) == SL);
        CORE_WE   = 1'b0;
        MON_WE    = 1'b0;
        CORE_ADDR = 11'($urandom);
        MON_ADDR  = 11'($urandom);
        CORE_REQ  = 1'b1;
        MON_REQ   = 1'b1;
        for (int k = 0; k < 10 * (AC + 3) + 10 && n < 10; k++) begin
            tick();
            if (CORE_ACK && MON_ACK) overlap++;
            if (CORE_ACK || MON_ACK) begin
                got[n] = MON_ACK;
                if (last >= 0 && k - last != AC + 3) bad_gap++;
                last = k;
                n++;
            end
        end
        CORE_REQ = 1'b0;
        MON_REQ  = 1'b0;
        n_checks++;
        if (n != 10) begin
            n_fail++;
            $display("FAIL starve_grant_count: got %0d expected 10", n);
        end
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL starve_order (bit i = monitor): got %b expected %b", got, want);
        end
        n_checks++;
        if (bad_gap != 0 || overlap != 0) begin
            n_fail++;
            $display("FAIL starve_spacing: got %0d bad gaps %0d overlaps expected 0 0", bad_gap, overlap);
        end
    endtask

    task automatic test_no_starve();
        int cack = 0, mack = 0, last = -1, bad_gap = 0;
        CORE_REQ = 1'b1;
        MON_REQ  = 1'b1;
        for (int k = 0; k < 6 * (AC + 3) + AC + 1; k++) begin
            tick();
            if (n_mon_ack) mack++;
            if (n_core_ack) begin
                if (last >= 0 && k - last != AC + 3) bad_gap++;
                last = k;
                cack++;
            end
        end
        CORE_REQ = 1'b0;
        MON_REQ  = 1'b0;
        n_checks++;
        if (mack != 0) begin
            n_fail++;
            $display("FAIL nostarve_mon_grants: got %0d expected 0", mack);
        end
        n_checks++;
        if (cack != 6 || bad_gap != 0) begin
            n_fail++;
            $display("FAIL nostarve_core_rate: got %0d acks %0d bad gaps expected 6 0", cack, bad_gap);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [10:0] a = 11'($urandom);
        logic [15:0] v = 16'($urandom);
        int acks = 0;
        CORE_WE    = 1'b1;
        CORE_ADDR  = a;
        CORE_WDATA = v;
        CORE_REQ   = 1'b1;
        tick();
        tick();
        n_checks++;
        if (MEM_WE_n !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_write_active: got we_n %b expected 0", MEM_WE_n);
        end
        tick();
        SIM_RST = 1'b1;
        tick();
        n_checks++;
        if ({MEM_CE_n, MEM_OE_n, MEM_WE_n, MEM_DOE, CORE_ACK, MON_ACK, BUSY} !== 7'b1110000) begin
            n_fail++;
            $display("FAIL abort_outputs: got %b expected 1110000",
                     {MEM_CE_n, MEM_OE_n, MEM_WE_n, MEM_DOE, CORE_ACK, MON_ACK, BUSY});
        end
        SIM_RST = 1'b0;
        for (int k = 0; k < AC + 6; k++) begin
            tick();
            if (CORE_ACK) begin
                acks++;
                CORE_REQ = 1'b0;
            end
        end
        n_checks++;
        if (acks != 1) begin
            n_fail++;
            $display("FAIL abort_regrant_ack: got %0d expected 1", acks);
        end
        n_checks++;
        if (mem_dev[a] !== v) begin
            n_fail++;
            $display("FAIL abort_regrant_data: got %0h expected %0h", mem_dev[a], v);
        end
    endtask

    task automatic test_drop_req();
        logic [10:0] a = 11'($urandom);
        int addr_bad = 0, acks = 0;
        CORE_WE   = 1'b0;
        CORE_ADDR = a;
        CORE_REQ  = 1'b1;
        tick();
        CORE_REQ  = 1'b0;
        CORE_ADDR = ~a;
        if (MEM_ADDR !== a) addr_bad++;
        for (int k = 0; k < AC + 5; k++) begin
            tick();
            if (BUSY && MEM_ADDR !== a) addr_bad++;
            if (CORE_ACK) acks++;
        end
        n_checks++;
        if (addr_bad != 0) begin
            n_fail++;
            $display("FAIL drop_addr_stable: got %0d bad cycles expected 0", addr_bad);
        end
        n_checks++;
        if (acks != 1) begin
            n_fail++;
            $display("FAIL drop_ack: got %0d expected 1", acks);
        end
        n_checks++;
        if (RDATA !== mem_ref[a]) begin
            n_fail++;
            $display("FAIL drop_rdata: got %0h expected %0h", RDATA, mem_ref[a]);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            tick();
            n_checks++;
            if ({MEM_CE_n, MEM_OE_n, MEM_WE_n, MEM_DOE, BUSY} !==
                {exp_ce_n, exp_oe_n, exp_we_n, exp_doe, exp_busy}) begin
                n_fail++;
                $display("FAIL rand_strobes cyc %0d: got %b expected %b", cyc,
                         {MEM_CE_n, MEM_OE_n, MEM_WE_n, MEM_DOE, BUSY},
                         {exp_ce_n, exp_oe_n, exp_we_n, exp_doe, exp_busy});
            end
            n_checks++;
            if ({CORE_ACK, MON_ACK} !== {exp_cack, exp_mack}) begin
                n_fail++;
                $display("FAIL rand_acks cyc %0d: got %b expected %b", cyc,
                         {CORE_ACK, MON_ACK}, {exp_cack, exp_mack});
            end
            n_checks++;
            if (MEM_ADDR !== exp_addr) begin
                n_fail++;
                $display("FAIL rand_addr cyc %0d: got %0h expected %0h", cyc, MEM_ADDR, exp_addr);
            end
            n_checks++;
            if (RDATA !== exp_rdata) begin
                n_fail++;
                $display("FAIL rand_rdata cyc %0d: got %0h expected %0h", cyc, RDATA, exp_rdata);
            end
            if (exp_doe) begin
                n_checks++;
                if (MEM_DOUT !== exp_dout) begin
                    n_fail++;
                    $display("FAIL rand_dout cyc %0d: got %0h expected %0h", cyc, MEM_DOUT, exp_dout);
                end
            end
            if (CORE_ACK) CORE_REQ = 1'b0;
            else if (!CORE_REQ && $urandom_range(0, 2) == 0) CORE_REQ = 1'b1;
            if (MON_ACK) MON_REQ = 1'b0;
            else if (!MON_REQ && $urandom_range(0, 2) == 0) MON_REQ = 1'b1;
            // Request fields wander every cycle; only the value at grant may matter
            if (CORE_REQ) begin
                CORE_WE    = 1'($urandom_range(0, 1));
                CORE_ADDR  = 11'($urandom_range(0, 15));
                CORE_WDATA = 16'($urandom);
            end
            if (MON_REQ) begin
                MON_WE    = 1'($urandom_range(0, 1));
                MON_ADDR  = 11'($urandom_range(0, 15));
                MON_WDATA = 16'($urandom);
            end
        end
    endtask

    initial begin
        SIM_RST    = 1'b1;
        CORE_REQ   = 1'b0;
        CORE_WE    = 1'b0;
        CORE_ADDR  = '0;
        CORE_WDATA = '0;
        MON_REQ    = 1'b0;
        MON_WE     = 1'b0;
        MON_ADDR   = '0;
        MON_WDATA  = '0;
        for (int i = 0; i < 2048; i++) begin
            mem_dev[i] = 16'($urandom);
            mem_ref[i] = mem_dev[i];
        end
        test_reset();
        test_core_read();
        idle(3);
        test_mon_write();
        idle(3);
        test_starvation();
        idle(AC + 5);
        test_no_starve();
        idle(AC + 5);
        test_reset_mid_write();
        idle(3);
        test_drop_req();
        idle(3);
        test_random();
        idle(AC + 5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
